// File: rtl/dpi_prot_pkg.sv
// Shared widths and types for the protected accumulator/pass-through block.
// Channel widths straddle the 32/64/128-bit word boundaries on purpose.
package dpi_prot_pkg;

  localparam int ACCUM_W = 32;
  localparam int S_NUM = 7;
  localparam int S_WIDTHS [S_NUM] = '{1, 2, 8, 33, 64, 65, 129};

  typedef logic [ACCUM_W-1:0] accum_t;
  typedef logic [0:0]   s1_t;
  typedef logic [1:0]   s2_t;
  typedef logic [7:0]   s8_t;
  typedef logic [32:0]  s33_t;
  typedef logic [63:0]  s64_t;
  typedef logic [64:0]  s65_t;
  typedef logic [128:0] s129_t;

endpackage

// File: rtl/dpi_prot_passthru.sv
// Zero-latency, full-width wire-through for one channel.
module dpi_prot_passthru #(
  parameter int W = 1
) (
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_d
);

  assign o_d = i_d;

endmodule

// File: rtl/dpi_prot_secret.sv
// Registered 32-bit running accumulator plus combinational pass-through channels.
// The sum wraps modulo 2^ACCUM_W; rst clears it synchronously.
module dpi_prot_secret
  import dpi_prot_pkg::*;
#(
  parameter int ACCUM_W = dpi_prot_pkg::ACCUM_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ACCUM_W-1:0] accum_in,
  output logic [ACCUM_W-1:0] accum_out,
  input  logic               s1_in,
  output logic               s1_out,
  input  logic [1:0]         s2_in,
  output logic [1:0]         s2_out,
  input  logic [7:0]         s8_in,
  output logic [7:0]         s8_out,
  input  logic [32:0]        s33_in,
  output logic [32:0]        s33_out,
  input  logic [63:0]        s64_in,
  output logic [63:0]        s64_out,
  input  logic [64:0]        s65_in,
  output logic [64:0]        s65_out,
  input  logic [128:0]       s129_in,
  output logic [128:0]       s129_out
);

  // Power-up value of 0 so a parent that never pulses rst still starts from zero.
  logic [ACCUM_W-1:0] r_accum = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_accum <= '0;
    end else begin
      r_accum <= r_accum + accum_in;
    end
  end

  assign accum_out = r_accum;

  dpi_prot_passthru #(.W(S_WIDTHS[0])) u_pt_s1 (
    .i_d (s1_in),
    .o_d (s1_out)
  );

  dpi_prot_passthru #(.W(S_WIDTHS[1])) u_pt_s2 (
    .i_d (s2_in),
    .o_d (s2_out)
  );

  dpi_prot_passthru #(.W(S_WIDTHS[2])) u_pt_s8 (
    .i_d (s8_in),
    .o_d (s8_out)
  );

  dpi_prot_passthru #(.W(S_WIDTHS[3])) u_pt_s33 (
    .i_d (s33_in),
    .o_d (s33_out)
  );

  dpi_prot_passthru #(.W(S_WIDTHS[4])) u_pt_s64 (
    .i_d (s64_in),
    .o_d (s64_out)
  );

  dpi_prot_passthru #(.W(S_WIDTHS[5])) u_pt_s65 (
    .i_d (s65_in),
    .o_d (s65_out)
  );

  dpi_prot_passthru #(.W(S_WIDTHS[6])) u_pt_s129 (
    .i_d (s129_in),
    .o_d (s129_out)
  );

endmodule

// File: tb/tb_dpi_prot_secret.sv
// Bench for dpi_prot_secret: accumulator vectors, two-instance independence,
// randomized accumulation against a sum model, and pass-through bit patterns.
module tb_dpi_prot_secret;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_failed = 0;

  // Instance A
  logic         a_rst = 1'b0;
  logic [31:0]  a_in = '0;
  logic [31:0]  a_out;
  logic         s1_in = '0;
  logic         s1_out;
  logic [1:0]   s2_in = '0;
  logic [1:0]   s2_out;
  logic [7:0]   s8_in = '0;
  logic [7:0]   s8_out;
  logic [32:0]  s33_in = '0;
  logic [32:0]  s33_out;
  logic [63:0]  s64_in = '0;
  logic [63:0]  s64_out;
  logic [64:0]  s65_in = '0;
  logic [64:0]  s65_out;
  logic [128:0] s129_in = '0;
  logic [128:0] s129_out;

  // Instance B
  logic         b_rst = 1'b0;
  logic [31:0]  b_in = '0;
  logic [31:0]  b_out;
  logic         b_s1_out;
  logic [1:0]   b_s2_out;
  logic [7:0]   b_s8_out;
  logic [32:0]  b_s33_out;
  logic [63:0]  b_s64_out;
  logic [64:0]  b_s65_out;
  logic [128:0] b_s129_out;

  dpi_prot_secret u_dut_a (
    .clk      (clk),
    .rst      (a_rst),
    .accum_in (a_in),
    .accum_out(a_out),
    .s1_in    (s1_in),
    .s1_out   (s1_out),
    .s2_in    (s2_in),
    .s2_out   (s2_out),
    .s8_in    (s8_in),
    .s8_out   (s8_out),
    .s33_in   (s33_in),
    .s33_out  (s33_out),
    .s64_in   (s64_in),
    .s64_out  (s64_out),
    .s65_in   (s65_in),
    .s65_out  (s65_out),
    .s129_in  (s129_in),
    .s129_out (s129_out)
  );

  dpi_prot_secret u_dut_b (
    .clk      (clk),
    .rst      (b_rst),
    .accum_in (b_in),
    .accum_out(b_out),
    .s1_in    (1'b0),
    .s1_out   (b_s1_out),
    .s2_in    (2'b0),
    .s2_out   (b_s2_out),
    .s8_in    (8'b0),
    .s8_out   (b_s8_out),
    .s33_in   (33'b0),
    .s33_out  (b_s33_out),
    .s64_in   (64'b0),
    .s64_out  (b_s64_out),
    .s65_in   (65'b0),
    .s65_out  (b_s65_out),
    .s129_in  (129'b0),
    .s129_out (b_s129_out)
  );

  task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [31:0] in;
    logic [31:0] exp;
  } acc_vec_t;

  typedef struct {
    logic [128:0] pat;
    logic         rst;
    string        name;
  } pt_vec_t;

  acc_vec_t acc_tbl[$];
  pt_vec_t  pt_tbl[$];

  task automatic drive_pt(input logic [128:0] p);
    s1_in   = p[0];
    s2_in   = p[1:0];
    s8_in   = p[7:0];
    s33_in  = p[32:0];
    s64_in  = p[63:0];
    s65_in  = p[64:0];
    s129_in = p;
  endtask

  task automatic check_pt(input string tag, input logic [128:0] p);
    chk({tag, " s1"},   {128'b0, s1_out},  {128'b0, p[0]});
    chk({tag, " s2"},   {127'b0, s2_out},  {127'b0, p[1:0]});
    chk({tag, " s8"},   {121'b0, s8_out},  {121'b0, p[7:0]});
    chk({tag, " s33"},  {96'b0, s33_out},  {96'b0, p[32:0]});
    chk({tag, " s64"},  {65'b0, s64_out},  {65'b0, p[63:0]});
    chk({tag, " s65"},  {64'b0, s65_out},  {64'b0, p[64:0]});
    chk({tag, " s129"}, s129_out,          p);
  endtask

  initial begin
    int bitpos [7];
    logic [128:0] one;
    logic [128:0] deadbeef;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] r;

    bitpos = '{0, 31, 32, 63, 64, 127, 128};
    one = 129'd1;
    deadbeef = {1'b1, 128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF};

    // Power-up value before any reset
    #1;
    chk("powerup A", {97'b0, a_out}, 129'd0);
    chk("powerup B", {97'b0, b_out}, 129'd0);

    // Accumulator vectors: expected sums derived by hand from sum(n+1)=sum(n)+in(n)
    acc_tbl.push_back('{1'b1, 32'd5,          32'd0});
    acc_tbl.push_back('{1'b1, 32'd5,          32'd0});
    acc_tbl.push_back('{1'b0, 32'd5,          32'd5});
    acc_tbl.push_back('{1'b0, 32'd5,          32'd10});
    acc_tbl.push_back('{1'b0, 32'd5,          32'd15});
    acc_tbl.push_back('{1'b1, 32'd0,          32'd0});
    acc_tbl.push_back('{1'b0, 32'd100,        32'd100});
    acc_tbl.push_back('{1'b0, 32'd105,        32'd205});
    acc_tbl.push_back('{1'b0, 32'd110,        32'd315});
    acc_tbl.push_back('{1'b0, 32'd115,        32'd430});
    acc_tbl.push_back('{1'b1, 32'd7,          32'd0});
    acc_tbl.push_back('{1'b0, 32'd7,          32'd7});
    acc_tbl.push_back('{1'b1, 32'd0,          32'd0});
    acc_tbl.push_back('{1'b0, 32'hFFFF_FFF0,  32'hFFFF_FFF0});
    acc_tbl.push_back('{1'b0, 32'h0000_0020,  32'h0000_0010});
    acc_tbl.push_back('{1'b0, 32'h0000_0000,  32'h0000_0010});

    @(negedge clk);
    for (int i = 0; i < acc_tbl.size(); i++) begin
      a_rst = acc_tbl[i].rst;
      a_in  = acc_tbl[i].in;
      #1;
      // Output must not move until the next edge
      if (i > 0) chk($sformatf("acc hold %0d", i), {97'b0, a_out}, {97'b0, acc_tbl[i-1].exp});
      @(negedge clk);
      chk($sformatf("acc vec %0d", i), {97'b0, a_out}, {97'b0, acc_tbl[i].exp});
    end

    // Two instances in parallel
    a_rst = 1'b1; b_rst = 1'b1; a_in = 32'd0; b_in = 32'd0;
    @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;
    ma = 32'd0; mb = 32'd0;
    for (int k = 0; k < 6; k++) begin
      a_in = 32'(5 * k);
      b_in = 32'(100 + 5 * k);
      ma = ma + a_in;
      mb = mb + b_in;
      @(negedge clk);
      chk($sformatf("par A %0d", k), {97'b0, a_out}, {97'b0, ma});
      chk($sformatf("par B %0d", k), {97'b0, b_out}, {97'b0, mb});
    end

    // Randomized accumulation, independent resets, against a plain sum model
    for (int k = 0; k < 300; k++) begin
      r = $urandom;
      a_rst = ($urandom_range(0, 15) == 0);
      b_rst = ($urandom_range(0, 15) == 0);
      a_in = (r[3:0] == 4'h0) ? 32'hFFFF_FFFF : $urandom;
      b_in = (r[7:4] == 4'h0) ? 32'h8000_0000 : $urandom;
      ma = a_rst ? 32'd0 : ma + a_in;
      mb = b_rst ? 32'd0 : mb + b_in;
      @(negedge clk);
      chk($sformatf("rand A %0d", k), {97'b0, a_out}, {97'b0, ma});
      chk($sformatf("rand B %0d", k), {97'b0, b_out}, {97'b0, mb});
    end

    // Pass-through patterns, with rst low and high
    for (int rl = 0; rl < 2; rl++) begin
      pt_tbl.push_back('{'0, rl[0], "all0"});
      pt_tbl.push_back('{'1, rl[0], "all1"});
      for (int j = 0; j < 7; j++) begin
        pt_tbl.push_back('{one << bitpos[j], rl[0], $sformatf("one@%0d", bitpos[j])});
        pt_tbl.push_back('{~(one << bitpos[j]), rl[0], $sformatf("zero@%0d", bitpos[j])});
      end
      pt_tbl.push_back('{deadbeef, rl[0], "deadbeef"});
    end
    for (int k = 0; k < 8; k++) begin
      pt_tbl.push_back('{{$urandom, $urandom, $urandom, $urandom, 1'($urandom)},
                         1'($urandom), $sformatf("rand%0d", k)});
    end

    // Sample away from clock edges: offset into the low phase
    @(negedge clk);
    #1;
    for (int i = 0; i < pt_tbl.size(); i++) begin
      a_rst = pt_tbl[i].rst;
      drive_pt(pt_tbl[i].pat);
      #0;
      #0;
      check_pt($sformatf("pt %s rst=%0b", pt_tbl[i].name, pt_tbl[i].rst), pt_tbl[i].pat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule

// File: doc/dpi_prot_secret.md
Name: dpi_prot_secret

Overview:
- Small "secret" IP block that is delivered to integrators as a protected library.
- Contains one registered 32-bit running accumulator.
- Contains a set of combinational pass-through channels of assorted widths: 1, 2, 8, 33, 64, 65 and 129 bits.
- The channel widths deliberately straddle word boundaries (32/64/128) to exercise multi-word signal handling across the protected-library boundary.
- Instantiated per lane by its parent.

Parameters:
- ACCUM_W, 32, accumulator width. Only 32 is required to be supported.

Ports:
- clk  input  1  single clock, rising-edge active
- rst  input  1  synchronous, active-high reset
- accum_in  input  32  addend sampled every cycle
- accum_out  output  32  registered running sum
- s1_in  input  1  pass-through channel input
- s1_out  output  1  equals s1_in
- s2_in  input  2  pass-through channel input
- s2_out  output  2  equals s2_in
- s8_in  input  8  pass-through channel input
- s8_out  output  8  equals s8_in
- s33_in  input  33  pass-through channel input
- s33_out  output  33  equals s33_in
- s64_in  input  64  pass-through channel input
- s64_out  output  64  equals s64_in
- s65_in  input  65  pass-through channel input
- s65_out  output  65  equals s65_in
- s129_in  input  129  pass-through channel input
- s129_out  output  129  equals s129_in

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). Nothing happens asynchronously.
- Accumulator, on each rising clk edge:
  - If rst=1: accum_out <= 0.
  - Otherwise: accum_out <= accum_out + accum_in.
- Accumulator arithmetic is unsigned and modulo 2^32: wraps silently, no carry-out, no saturation.
- Accumulator latency: accum_in sampled at edge n appears in accum_out after edge n. Equivalently, accum_out(n+1) = accum_out(n) + accum_in(n).
- Reset asserted mid-operation: the sum is cleared at that edge, regardless of accum_in. The sample presented during reset is discarded. Accumulation resumes on the first edge with rst=0.
- Accumulator power-up value, before any reset, is 0 (initialise the register for simulation). A parent that never asserts rst must still see a sum starting at 0.
- Pass-through channels:
  - Purely combinational, zero latency: sN_out = sN_in bit-for-bit, full width, including the MSBs of 33/65/129 and bit 0.
  - Unaffected by rst and clk.
  - No sign extension and no truncation.
- No handshake. accum_in is consumed every cycle.
- Multiple instances share no state.

Decomposition:
- Package dpi_prot_pkg, containing:
  - localparams ACCUM_W=32 and S_WIDTHS {1,2,8,33,64,65,129};
  - typedefs accum_t = logic[31:0] and s129_t etc.
- No sub-module required. Optional helper dpi_prot_passthru #(W), one instance per channel, if the team prefers a uniform wiring style.
- Keep the accumulator inline.

Test Plan:
- Reset then count: rst=1 for 2 cycles, then accum_in=5 for 3 edges.
  - Required: accum_out = 0 during and right after reset.
  - Required: accum_out = 5, 10, 15 after each of the 3 edges.
- Varying addends: accum_in sequence 100,105,110,115 from reset.
  - Required: accum_out = 100, 205, 315, 430 after each edge.
  - Required: accum_out updates exactly one edge after the sample.
- Wrap-around: accumulator preloaded via 0xFFFFFFF0, then accum_in=0x20.
  - Required: accum_out = 0x00000010.
- Reset mid-operation: sum=430, assert rst with accum_in=7 for 1 edge, then accum_in=7.
  - Required: accum_out = 0, then 7.
- Pass-through walking ones/zeros: drive each channel with all-0, all-1, and single bit at positions 0, 31, 32, 63, 64, 127, 128 where width allows. Also drive s129_in = 0x1_DEADBEEF_CAFEBABE_01234567_89ABCDEF.
  - Required: each sN_out equals sN_in in the same delta, with no clock edge needed. Check this with rst held high as well.
- Two instances in parallel, with accum_in 0,5,10… versus 100,105,…
  - Required: independent sums 0,5,15… and 100,205,315…
